// File: rtl/cache_fill_ctrl_if.sv
// Cache fill controller bus interface.
//
// Bundles every cache-side and memory-side signal of cache_fill_ctrl so the
// controller and its environment connect through one port.
//   slave  : the controller's view (cache requests and memory responses in;
//            fill results and memory strobes out)
//   master : the environment's view (cache and main memory), directions mirrored
//
// Cache side : miss_req, miss_addr, wb_req, wb_addr, wb_line  -> controller
//              busy, fill_valid, fill_line, fill_addr, err     <- controller
// Memory side: mem_addr, mem_wdata, mem_we, mem_re             <- controller
//              mem_rdata, mem_ready                            -> controller
interface cache_fill_ctrl_if;
   logic         miss_req;
   logic [31:0]  miss_addr;
   logic         wb_req;
   logic [31:0]  wb_addr;
   logic [255:0] wb_line;
   logic         busy;
   logic         fill_valid;
   logic [255:0] fill_line;
   logic [31:0]  fill_addr;
   logic         err;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         mem_we;
   logic         mem_re;
   logic [31:0]  mem_rdata;
   logic         mem_ready;

   modport slave (
      input  miss_req, miss_addr, wb_req, wb_addr, wb_line,
      input  mem_rdata, mem_ready,
      output busy, fill_valid, fill_line, fill_addr, err,
      output mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output miss_req, miss_addr, wb_req, wb_addr, wb_line,
      output mem_rdata, mem_ready,
      input  busy, fill_valid, fill_line, fill_addr, err,
      input  mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller.
//
// On a cache miss, optionally writes the dirty victim line back to main memory
// (8 word beats), then reads the missing line (8 word beats), assembles it and
// presents it with a one-cycle fill_valid pulse. A beat that waits
// TIMEOUT_CYCLES cycles for mem_ready aborts the request with an err pulse.
//
// Ports:
//   clk    : sole clock, all state changes on its rising edge
//   reset  : synchronous, active-high
//   bus    : cache_fill_ctrl_if.slave -- cache request/fill signals and the
//            word-wide main memory port (see the interface file)
// Parameter:
//   TIMEOUT_CYCLES : wait cycles tolerated on one beat before aborting (2..255)
module cache_fill_ctrl #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   cache_fill_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      RD   = 2'd2,
      FILL = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t        state_reg, state_next;
   logic [2:0]    beat_reg;
   logic [7:0]    wait_reg;
   logic [26:0]   line_addr_reg;
   logic [26:0]   wb_addr_reg;
   logic [255:0]  wb_line_reg;
   logic [255:0]  rd_line_reg;
   logic [255:0]  rd_line_next;
   logic [255:0]  fill_line_reg;
   logic [31:0]   fill_addr_reg;

   logic [31:0]   wb_word [8];
   logic [31:0]   wb_word_sel;
   logic          active;
   logic          timeout;
   logic          we_int;
   logic          re_int;
   logic          beat_done;
   logic          last_beat;
   logic          accept;

   // Line-offset bits of the cache addresses carry no information here.
   logic          unused_addr_bits;
   assign unused_addr_bits = ^{bus.miss_addr[4:0], bus.wb_addr[4:0]};

   // Word views of the captured victim line, and the read line with the
   // current beat's word replaced by the incoming memory data.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_word
         assign wb_word[gi] = wb_line_reg[32*gi +: 32];
         assign rd_line_next[32*gi +: 32] = (beat_reg == 3'(gi)) ? bus.mem_rdata
                                                                  : rd_line_reg[32*gi +: 32];
      end
   endgenerate

   assign wb_word_sel = wb_word[beat_reg];

   // Next-state and strobe logic. The timeout cycle is a one-cycle abort
   // inside WB/RD: strobes are already dropped and err is raised, so any
   // mem_ready in that cycle cannot complete a beat.
   always_comb begin
      state_next = state_reg;
      active     = (state_reg == WB) || (state_reg == RD);
      timeout    = active && (wait_reg == TIMEOUT_LIMIT);
      we_int     = (state_reg == WB) && !timeout;
      re_int     = (state_reg == RD) && !timeout;
      beat_done  = (we_int || re_int) && bus.mem_ready;
      last_beat  = beat_done && (beat_reg == 3'd7);
      accept     = (state_reg == IDLE) && bus.miss_req;

      case (state_reg)
         IDLE: begin
            if (bus.miss_req) begin
               state_next = bus.wb_req ? WB : RD;
            end
         end
         WB: begin
            if (timeout) begin
               state_next = IDLE;
            end else if (last_beat) begin
               state_next = RD;
            end
         end
         RD: begin
            if (timeout) begin
               state_next = IDLE;
            end else if (last_beat) begin
               state_next = FILL;
            end
         end
         FILL: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         beat_reg      <= 3'd0;
         wait_reg      <= 8'd0;
         line_addr_reg <= 27'd0;
         wb_addr_reg   <= 27'd0;
         wb_line_reg   <= 256'd0;
         rd_line_reg   <= 256'd0;
         fill_line_reg <= 256'd0;
         fill_addr_reg <= 32'd0;
      end else begin
         state_reg <= state_next;

         if (accept) begin
            line_addr_reg <= bus.miss_addr[31:5];
            wb_addr_reg   <= bus.wb_addr[31:5];
            wb_line_reg   <= bus.wb_line;
         end

         // Wait counter measures consecutive unanswered cycles of one beat.
         if (!active || timeout || beat_done) begin
            wait_reg <= 8'd0;
         end else begin
            wait_reg <= wait_reg + 8'd1;
         end

         // Beat counter wraps 7 -> 0 naturally on the WB-to-RD transition.
         if (!active || timeout) begin
            beat_reg <= 3'd0;
         end else if (beat_done) begin
            beat_reg <= beat_reg + 3'd1;
         end

         // The line is assembled privately and published only on the last
         // read beat, so fill_line/fill_addr keep the previous fill until then.
         if (re_int && bus.mem_ready) begin
            rd_line_reg <= rd_line_next;
            if (beat_reg == 3'd7) begin
               fill_line_reg <= rd_line_next;
               fill_addr_reg <= {line_addr_reg, 5'b00000};
            end
         end
      end
   end

   assign bus.busy       = (state_reg != IDLE);
   assign bus.fill_valid = (state_reg == FILL);
   assign bus.err        = timeout;
   assign bus.fill_line  = fill_line_reg;
   assign bus.fill_addr  = fill_addr_reg;
   assign bus.mem_we     = we_int;
   assign bus.mem_re     = re_int;
   assign bus.mem_addr   = we_int ? {wb_addr_reg, beat_reg, 2'b00} :
                           re_int ? {line_addr_reg, beat_reg, 2'b00} : 32'd0;
   assign bus.mem_wdata  = we_int ? wb_word_sel : 32'd0;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: directed scenarios followed by
// randomized requests, all checked against a behavioural model built from the
// expected beat list of each request and a simple address-to-data memory.
module tb_cache_fill_ctrl;
   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   bit   data_mode = 1'b0;
   logic [255:0] last_fill = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cache_fill_ctrl_if bus();

   cache_fill_ctrl #(.TIMEOUT_CYCLES(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Main memory contents as a function of word address.
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (!data_mode) return {29'd0, a[4:2]};
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         chk1("idle_busy", bus.busy, 1'b0);
         chk1("idle_strobe", bus.mem_re | bus.mem_we, 1'b0);
         chk1("idle_fill", bus.fill_valid, 1'b0);
         chk256("fill_hold", bus.fill_line, last_fill);
         bus.miss_req  = 1'b0;
         bus.mem_ready = 1'($urandom);
         bus.mem_rdata = $urandom;
      end
   endtask

   // One complete request. smin/smax bound the wait cycles inserted per beat;
   // noise scrambles the cache-side inputs (including miss_req) while busy.
   task automatic run_req(input logic [31:0] maddr, input logic wbq, input logic [31:0] waddr,
                          input logic [255:0] wline, input int smin, input int smax,
                          input bit noise);
      logic [31:0]  q_addr[$];
      logic [31:0]  q_data[$];
      logic         q_we[$];
      logic [255:0] exp_line;
      int           cyc, w, s, exp_fill;
      bit           done;
      for (int i = 0; i < 8; i++) begin
         exp_line[32*i +: 32] = mem_model({maddr[31:5], 3'(i), 2'b00});
         if (wbq) begin
            q_addr.push_back({waddr[31:5], 3'(i), 2'b00});
            q_data.push_back(wline[32*i +: 32]);
            q_we.push_back(1'b1);
         end
      end
      for (int i = 0; i < 8; i++) begin
         q_addr.push_back({maddr[31:5], 3'(i), 2'b00});
         q_data.push_back(exp_line[32*i +: 32]);
         q_we.push_back(1'b0);
      end

      @(negedge clk);
      chk1("accept_busy", bus.busy, 1'b0);
      chk1("accept_strobe", bus.mem_re | bus.mem_we, 1'b0);
      bus.miss_req  = 1'b1;
      bus.miss_addr = maddr;
      bus.wb_req    = wbq;
      bus.wb_addr   = waddr;
      bus.wb_line   = wline;
      bus.mem_ready = 1'($urandom);
      cyc = 0; w = 0; exp_fill = 1; done = 1'b0;
      s = int'($urandom_range(smax, smin));
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (noise) begin
            bus.miss_req  = 1'($urandom);
            bus.miss_addr = $urandom;
            bus.wb_req    = 1'($urandom);
            bus.wb_addr   = $urandom;
            bus.wb_line   = rand_line();
         end else begin
            bus.miss_req = 1'b0;
         end
         chk1("busy", bus.busy, 1'b1);
         chk1("err_low", bus.err, 1'b0);
         chk1("strobe_excl", bus.mem_re & bus.mem_we, 1'b0);
         chk1("strobe", bus.mem_re | bus.mem_we, q_addr.size() != 0);
         chk1("fill_valid", bus.fill_valid, q_addr.size() == 0);
         if (q_addr.size() == 0 || bus.fill_valid || !bus.busy) begin
            done = 1'b1;
            chk32("fill_cycle", 32'(cyc), 32'(exp_fill));
            chk32("fill_addr", bus.fill_addr, {maddr[31:5], 5'b00000});
            chk256("fill_line", bus.fill_line, exp_line);
            bus.mem_ready = 1'($urandom);
         end else begin
            chk1("mem_we", bus.mem_we, q_we[0]);
            chk32("mem_addr", bus.mem_addr, q_addr[0]);
            if (q_we[0]) chk32("mem_wdata", bus.mem_wdata, q_data[0]);
            if (w >= s) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = q_we[0] ? $urandom : mem_model(bus.mem_addr);
               void'(q_addr.pop_front());
               void'(q_data.pop_front());
               void'(q_we.pop_front());
               exp_fill += 1 + s;
               w = 0;
               s = int'($urandom_range(smax, smin));
            end else begin
               bus.mem_ready = 1'b0;
               bus.mem_rdata = $urandom;
               w++;
            end
         end
      end
      chk1("req_finished", done, 1'b1);
      bus.miss_req = 1'b0;
      last_fill = exp_line;
      $display("req maddr=%h wb=%0d waddr=%h cycles=%0d noise=%0d", maddr, wbq, waddr, cyc, noise);
   endtask

   initial begin
      logic [255:0] l;
      reset         = 1'b1;
      bus.miss_req  = 1'b0;
      bus.miss_addr = '0;
      bus.wb_req    = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_line   = '0;
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_fill_valid", bus.fill_valid, 1'b0);
      chk1("rst_err", bus.err, 1'b0);
      chk1("rst_we", bus.mem_we, 1'b0);
      chk1("rst_re", bus.mem_re, 1'b0);
      chk256("rst_fill_line", bus.fill_line, 256'd0);
      chk32("rst_fill_addr", bus.fill_addr, 32'd0);
      chk32("rst_mem_addr", bus.mem_addr, 32'd0);
      chk32("rst_mem_wdata", bus.mem_wdata, 32'd0);
      reset = 1'b0;
      $display("reset released");
      idle_cycles(2);

      // Plain read, memory answers with the beat index.
      run_req(32'h0000_1234, 1'b0, 32'h0, 256'h0, 0, 0, 1'b0);
      idle_cycles(1);

      // Writeback followed by read.
      for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'h0000_AA00 + 32'(i);
      run_req(32'h0000_5678, 1'b1, 32'h0000_A0E0, l, 0, 0, 1'b0);
      idle_cycles(1);

      // Three wait cycles on every beat.
      data_mode = 1'b1;
      run_req(32'h1357_9BDF, 1'b0, 32'h0, 256'h0, 3, 3, 1'b0);
      run_req(32'h0BAD_F00D, 1'b1, 32'hCAFE_0040, rand_line(), 3, 3, 1'b0);
      idle_cycles(1);

      // Timeout: mem_ready never comes on beat 0.
      @(negedge clk);
      bus.miss_req  = 1'b1;
      bus.miss_addr = 32'h0000_4467;
      bus.wb_req    = 1'b0;
      bus.mem_ready = 1'b0;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         bus.miss_req = 1'b0;
         chk1("to_re", bus.mem_re, 1'b1);
         chk1("to_err_low", bus.err, 1'b0);
         chk32("to_addr", bus.mem_addr, 32'h0000_4460);
         bus.mem_ready = 1'b0;
      end
      @(negedge clk);
      chk1("to_err", bus.err, 1'b1);
      chk1("to_strobe_drop", bus.mem_re | bus.mem_we, 1'b0);
      chk1("to_no_fill", bus.fill_valid, 1'b0);
      bus.mem_ready = 1'b1;
      $display("timeout request maddr=00004467 aborted");
      // Accepted in the cycle right after err.
      run_req(32'h0000_8800, 1'b0, 32'h0, 256'h0, 0, 1, 1'b0);

      // Reset during read beat 4.
      @(negedge clk);
      bus.miss_req  = 1'b1;
      bus.miss_addr = 32'h0000_7788;
      bus.wb_req    = 1'b0;
      bus.mem_ready = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         bus.miss_req = 1'b0;
         chk32("rmid_addr", bus.mem_addr, {27'h0000_3BC, 3'(c - 1), 2'b00});
         bus.mem_rdata = mem_model(bus.mem_addr);
         bus.mem_ready = 1'b1;
         if (c == 5) reset = 1'b1;
      end
      @(negedge clk);
      chk1("rmid_busy", bus.busy, 1'b0);
      chk1("rmid_fill_valid", bus.fill_valid, 1'b0);
      chk1("rmid_err", bus.err, 1'b0);
      chk1("rmid_strobe", bus.mem_re | bus.mem_we, 1'b0);
      chk256("rmid_fill_line", bus.fill_line, 256'd0);
      chk32("rmid_fill_addr", bus.fill_addr, 32'd0);
      chk32("rmid_mem_addr", bus.mem_addr, 32'd0);
      chk32("rmid_mem_wdata", bus.mem_wdata, 32'd0);
      reset = 1'b0;
      last_fill = '0;
      $display("reset during read beat 4");
      idle_cycles(2);
      run_req(32'h0000_7788, 1'b1, 32'h0000_9900, rand_line(), 0, 1, 1'b0);

      // Requests while busy are ignored; back-to-back request right after FILL.
      run_req(32'h2222_0000, 1'b1, 32'h3333_0020, rand_line(), 0, 2, 1'b1);
      run_req(32'h4444_0040, 1'b0, 32'h0, 256'h0, 0, 0, 1'b0);
      run_req(32'h5555_0060, 1'b0, 32'h0, 256'h0, 0, 2, 1'b1);
      idle_cycles(1);

      // Randomized requests.
      for (int r = 0; r < 20; r++) begin
         run_req($urandom, 1'($urandom), $urandom, rand_line(), 0, int'($urandom_range(2, 0)),
                 1'($urandom));
         idle_cycles(int'($urandom_range(2, 0)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max cycles waited for mem_ready on one beat (legal range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port miss_req  input  1  cache miss request; sampled only in IDLE.
REQ-005 SHALL have port miss_addr  input  32  missing address; bits [4:0] ignored.
REQ-006 SHALL have port wb_req  input  1  victim dirty, write back first; sampled only with miss_req.
REQ-007 SHALL have port wb_addr  input  32  victim line address; bits [4:0] ignored.
REQ-008 SHALL have port wb_line  input  256  victim line data, word i at bits [32i+31:32i].
REQ-009 SHALL have port busy  output  1  request in progress.
REQ-010 SHALL have port fill_valid  output  1  one-cycle pulse, fill_line/fill_addr valid.
REQ-011 SHALL have port fill_line  output  256  assembled line, same word packing as wb_line.
REQ-012 SHALL have port fill_addr  output  32  {miss_addr[31:5],5'b0} of the filled line.
REQ-013 SHALL have port err  output  1  one-cycle pulse on memory timeout.
REQ-014 SHALL have port mem_addr  output  32  word address to main memory.
REQ-015 SHALL have port mem_wdata  output  32  write data to main memory.
REQ-016 SHALL have port mem_we / mem_re  output  1 each  write / read strobe; never both high.
REQ-017 SHALL have port mem_rdata  input  32  read data, valid when mem_ready high during mem_re.
REQ-018 SHALL have port mem_ready  input  1  beat completes on any cycle mem_ready=1 with mem_re or mem_we high.

Function
REQ-019 SHALL implement FSM states IDLE, WB, RD, FILL.
REQ-020 In IDLE with miss_req=1 SHALL capture miss_addr, wb_addr, wb_line, wb_req and go to WB if wb_req=1, else RD; busy=1 from next cycle.
REQ-021 SHALL ignore miss_req and all cache-side inputs while busy=1.
REQ-022 SHALL use 3-bit beat counter; beat i address = {line_addr[31:5], i[2:0], 2'b00}, beats ascending 0..7.
REQ-023 In WB SHALL hold mem_we=1, mem_addr, mem_wdata=captured word i stable until beat completes; after beat 7 go to RD, counter wraps to 0.
REQ-024 In RD SHALL hold mem_re=1, mem_addr stable until beat completes; store mem_rdata into fill_line word i at completion; after beat 7 go to FILL.
REQ-025 In FILL SHALL assert fill_valid=1 for exactly one cycle, busy=1, then IDLE with busy=0.
REQ-026 fill_line and fill_addr SHALL hold their value until next fill completes.
REQ-027 With mem_ready tied high: no writeback, fill_valid at cycle 9 after accept cycle 0; with writeback, fill_valid at cycle 17.
REQ-028 SHALL count wait cycles per beat, clearing on each completed beat; upon TIMEOUT_CYCLES consecutive cycles without mem_ready, SHALL pulse err=1 one cycle, drop mem_re/mem_we, go to IDLE, no fill_valid.
REQ-029 mem_ready when neither strobe high SHALL be ignored.
REQ-030 A new miss_req SHALL be acceptable in the cycle immediately after FILL or err.

Reset
REQ-031 reset=1 SHALL force IDLE, counters 0, busy, fill_valid, err, mem_we, mem_re = 0, fill_line, fill_addr, mem_addr, mem_wdata = 0.
REQ-032 reset mid-transfer SHALL abort without fill_valid or err; no memory strobe on the cycle after reset deasserts unless a new request is accepted.

Verification
REQ-033 miss_req, miss_addr=0x0000_1234, wb_req=0, mem_ready=1, mem_rdata=beat index -> mem_re addresses 0x1220..0x123C, fill_valid cycle 9, fill_addr=0x1220, fill_line words = 0..7.
REQ-034 wb_req=1, wb_addr=0x0000_A0E0, wb_line word i=0xAA00+i -> 8 writes 0xA0E0..0xA0FC with matching data, then 8 reads, fill_valid cycle 17.
REQ-035 mem_ready low 3 cycles on each beat -> mem_addr/mem_re stable while stalled, fill_line correct, fill_valid once.
REQ-036 mem_ready held low, TIMEOUT_CYCLES=64 -> err pulse after 64 wait cycles on beat 0, busy=0 next cycle, no fill_valid.
REQ-037 reset asserted during RD beat 4 -> all outputs 0 next cycle; subsequent request completes normally.
REQ-038 miss_req pulsed while busy, and back-to-back miss_req right after FILL -> busy-time request ignored, back-to-back accepted.
